pong_game_ctrl: RTL and testbench

Frame-rate game controller that sequences the Pong display datapath: it owns the ball position, ball direction, both paddle positions, scores and the serve/point/game-over state machine. Once per video frame it advances the game state, and its outputs drive the ball and paddle coordinate inputs of `display`. The player's paddle follows two buttons, and the AI paddle tracks the ball. All geometry parameters match `display` so collisions line up with what is drawn.

---
 rtl/pong_game_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Pong game controller: owns ball, paddles, scores and the serve/play/point/game-over
// sequence, advancing exactly once per frame_tick. All outputs are registered.
module pong_game_ctrl #(
    parameter int RIGHT_BOUNDARY  = 637,
    parameter int LEFT_BOUNDARY   = 3,
    parameter int TOP_BOUNDARY    = 3,
    parameter int BOTTOM_BOUNDARY = 477,
    parameter int PLAYER_PADDLE_X = 10,
    parameter int AI_PADDLE_X     = 620,
    parameter int PADDLE_WIDTH    = 10,
    parameter int PADDLE_HEIGHT   = 46,
    parameter int BALL_SIZE       = 10,
    parameter int BALL_SPEED      = 2,
    parameter int PADDLE_SPEED    = 3,
    parameter int AI_SPEED        = 2,
    parameter int WIN_SCORE       = 7,
    parameter int PAUSE_FRAMES    = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       serve,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] left_paddle,
    output logic [9:0] right_paddle,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic [1:0] state,
    output logic       point
);

    typedef enum logic [1:0] {
        ST_SERVE     = 2'd0,
        ST_PLAY      = 2'd1,
        ST_POINT     = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    localparam logic [10:0] TOP_L    = 11'(TOP_BOUNDARY);
    localparam logic [10:0] BOT_L    = 11'(BOTTOM_BOUNDARY);
    localparam logic [10:0] LEFT_L   = 11'(LEFT_BOUNDARY);
    localparam logic [10:0] RIGHT_L  = 11'(RIGHT_BOUNDARY);
    localparam logic [10:0] SIZE_L   = 11'(BALL_SIZE);
    localparam logic [10:0] HGT_L    = 11'(PADDLE_HEIGHT);
    localparam logic [10:0] BSPD_L   = 11'(BALL_SPEED);
    localparam logic [10:0] PSPD_L   = 11'(PADDLE_SPEED);
    localparam logic [10:0] ASPD_L   = 11'(AI_SPEED);
    localparam logic [10:0] FACE_L   = 11'(PLAYER_PADDLE_X + PADDLE_WIDTH);
    localparam logic [10:0] FACE_R   = 11'(AI_PADDLE_X - BALL_SIZE);
    localparam logic [10:0] BALL_MAX = 11'(BOTTOM_BOUNDARY - BALL_SIZE);
    localparam logic [10:0] PAD_MAX  = 11'(BOTTOM_BOUNDARY - PADDLE_HEIGHT);
    localparam logic [9:0]  CENTRE_X = 10'((LEFT_BOUNDARY + RIGHT_BOUNDARY) / 2 - BALL_SIZE / 2);
    localparam logic [9:0]  CENTRE_Y = 10'((TOP_BOUNDARY + BOTTOM_BOUNDARY) / 2 - BALL_SIZE / 2);
    localparam logic [9:0]  PAD_HOME = 10'((TOP_BOUNDARY + BOTTOM_BOUNDARY) / 2 - PADDLE_HEIGHT / 2);
    localparam logic [3:0]  WIN_L    = 4'(WIN_SCORE);
    localparam logic [7:0]  PAUSE_LAST = 8'(PAUSE_FRAMES - 1);

    state_t      state_q, state_d;
    logic [9:0]  ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic [9:0]  left_q, left_d, right_q, right_d;
    logic [3:0]  score_l_q, score_l_d, score_r_q, score_r_d;
    logic        dir_x_q, dir_x_d;  // 1 = moving right
    logic        dir_y_q, dir_y_d;  // 1 = moving down
    logic [7:0]  pause_q, pause_d;
    logic        point_q, point_d;
    logic [10:0] bx, by, bc, ac;

    // Both buttons (or neither) hold the paddle; motion saturates at the playfield edges.
    function automatic logic [9:0] step_paddle(input logic [9:0] p, input logic up,
                                               input logic dn, input logic [10:0] spd);
        logic [10:0] w;
        w = {1'b0, p};
        step_paddle = p;
        if (up && !dn)
            step_paddle = (w < TOP_L + spd) ? 10'(TOP_L) : 10'(w - spd);
        else if (dn && !up)
            step_paddle = (w + spd > PAD_MAX) ? 10'(PAD_MAX) : 10'(w + spd);
    endfunction

    function automatic logic overlaps(input logic [10:0] y, input logic [9:0] p);
        logic [10:0] pw;
        pw = {1'b0, p};
        return (y + SIZE_L > pw) && (y < pw + HGT_L);
    endfunction

    always_comb begin
        state_d   = state_q;
        ball_x_d  = ball_x_q;
        ball_y_d  = ball_y_q;
        left_d    = left_q;
        right_d   = right_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        pause_d   = pause_q;
        point_d   = 1'b0;
        bx = {1'b0, ball_x_q};
        by = {1'b0, ball_y_q};
        bc = by + 11'(BALL_SIZE / 2);
        ac = {1'b0, right_q} + 11'(PADDLE_HEIGHT / 2);

        if (frame_tick) begin
            unique case (state_q)
                ST_SERVE: begin
                    left_d   = step_paddle(left_q, btn_up, btn_down, PSPD_L);
                    ball_x_d = CENTRE_X;
                    ball_y_d = CENTRE_Y;
                    if (serve) begin
                        state_d = ST_PLAY;
                        dir_y_d = ~dir_y_q;
                    end
                end
                ST_PLAY: begin
                    left_d  = step_paddle(left_q, btn_up, btn_down, PSPD_L);
                    right_d = step_paddle(right_q, bc + ASPD_L < ac, bc > ac + ASPD_L, ASPD_L);

                    if (!dir_y_q) begin
                        if (by < TOP_L + BSPD_L) begin
                            ball_y_d = 10'(TOP_L);
                            dir_y_d  = 1'b1;
                        end else begin
                            ball_y_d = 10'(by - BSPD_L);
                        end
                    end else begin
                        if (by + SIZE_L + BSPD_L > BOT_L) begin
                            ball_y_d = 10'(BALL_MAX);
                            dir_y_d  = 1'b0;
                        end else begin
                            ball_y_d = 10'(by + BSPD_L);
                        end
                    end

                    // An overlapping paddle always wins over a miss; the scorer serves toward the loser.
                    if (!dir_x_q) begin
                        if (bx >= FACE_L && bx <= FACE_L + BSPD_L && overlaps(by, left_q)) begin
                            ball_x_d = 10'(FACE_L);
                            dir_x_d  = 1'b1;
                        end else if (bx < LEFT_L + BSPD_L) begin
                            score_r_d = score_r_q + 4'd1;
                            point_d   = 1'b1;
                            dir_x_d   = 1'b0;
                            state_d   = (score_r_q + 4'd1 == WIN_L) ? ST_GAME_OVER : ST_POINT;
                        end else begin
                            ball_x_d = 10'(bx - BSPD_L);
                        end
                    end else begin
                        if (bx <= FACE_R && bx + BSPD_L >= FACE_R && overlaps(by, right_q)) begin
                            ball_x_d = 10'(FACE_R);
                            dir_x_d  = 1'b0;
                        end else if (bx + SIZE_L + BSPD_L > RIGHT_L) begin
                            score_l_d = score_l_q + 4'd1;
                            point_d   = 1'b1;
                            dir_x_d   = 1'b1;
                            state_d   = (score_l_q + 4'd1 == WIN_L) ? ST_GAME_OVER : ST_POINT;
                        end else begin
                            ball_x_d = 10'(bx + BSPD_L);
                        end
                    end
                end
                ST_POINT: begin
                    if (pause_q == PAUSE_LAST) begin
                        pause_d  = 8'd0;
                        ball_x_d = CENTRE_X;
                        ball_y_d = CENTRE_Y;
                        state_d  = ST_SERVE;
                    end else begin
                        pause_d = pause_q + 8'd1;
                    end
                end
                ST_GAME_OVER: begin
                    if (serve) begin
                        score_l_d = 4'd0;
                        score_r_d = 4'd0;
                        ball_x_d  = CENTRE_X;
                        ball_y_d  = CENTRE_Y;
                        left_d    = PAD_HOME;
                        right_d   = PAD_HOME;
                        state_d   = ST_SERVE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_SERVE;
            ball_x_q  <= CENTRE_X;
            ball_y_q  <= CENTRE_Y;
            left_q    <= PAD_HOME;
            right_q   <= PAD_HOME;
            score_l_q <= 4'd0;
            score_r_q <= 4'd0;
            dir_x_q   <= 1'b1;
            dir_y_q   <= 1'b1;
            pause_q   <= 8'd0;
            point_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ball_x_q  <= ball_x_d;
            ball_y_q  <= ball_y_d;
            left_q    <= left_d;
            right_q   <= right_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            pause_q   <= pause_d;
            point_q   <= point_d;
        end
    end

    assign ball_x       = ball_x_q;
    assign ball_y       = ball_y_q;
    assign left_paddle  = left_q;
    assign right_paddle = right_q;
    assign score_left   = score_l_q;
    assign score_right  = score_r_q;
    assign state        = state_q;
    assign point        = point_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: a vector table for paddle/serve behaviour plus
// hand-computed full-game sequences for bounces, hits, misses, pause and game over.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       reset, frame_tick, btn_up, btn_down, serve;
    logic [9:0] ball_x, ball_y, left_paddle, right_paddle;
    logic [3:0] score_left, score_right;
    logic [1:0] state;
    logic       point;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int   n;
        logic up, dn, srv;
        int   bx, by, lp, rp, sl, sr, st, pt;
    } vec_t;

    vec_t tbl[13];

    pong_game_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_up(btn_up), .btn_down(btn_down), .serve(serve),
        .ball_x(ball_x), .ball_y(ball_y),
        .left_paddle(left_paddle), .right_paddle(right_paddle),
        .score_left(score_left), .score_right(score_right),
        .state(state), .point(point)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int n, input logic up, input logic dn, input logic srv,
                                input int bx, input int by, input int lp, input int rp,
                                input int sl, input int sr, input int st, input int pt);
        vec_t v;
        v.n = n; v.up = up; v.dn = dn; v.srv = srv;
        v.bx = bx; v.by = by; v.lp = lp; v.rp = rp;
        v.sl = sl; v.sr = sr; v.st = st; v.pt = pt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input int exp);
        total++;
        if (act !== 16'(exp)) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int bx, input int by, input int lp,
                           input int rp, input int sl, input int sr, input int st, input int pt);
        chk({tag, ".ball_x"}, 16'(ball_x), bx);
        chk({tag, ".ball_y"}, 16'(ball_y), by);
        chk({tag, ".left_paddle"}, 16'(left_paddle), lp);
        chk({tag, ".right_paddle"}, 16'(right_paddle), rp);
        chk({tag, ".score_left"}, 16'(score_left), sl);
        chk({tag, ".score_right"}, 16'(score_right), sr);
        chk({tag, ".state"}, 16'(state), st);
        chk({tag, ".point"}, 16'(point), pt);
    endtask

    // Each tick is a one-cycle frame_tick; we return on a falling edge right after it.
    task automatic do_ticks(input int n, input logic up, input logic dn, input logic srv);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_tick = 1'b1; btn_up = up; btn_down = dn; serve = srv;
            @(negedge clk);
            frame_tick = 1'b0; serve = 1'b0;
        end
    endtask

    task automatic reset_with_tick();
        @(negedge clk);
        reset = 1'b1; frame_tick = 1'b1;
        @(negedge clk);
        reset = 1'b0; frame_tick = 1'b0;
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; btn_up = 1'b0; btn_down = 1'b0; serve = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        tbl[0]  = mk(0,   0, 0, 0, 315, 235, 217, 217, 0, 0, 0, 0);
        tbl[1]  = mk(5,   0, 0, 0, 315, 235, 217, 217, 0, 0, 0, 0);
        tbl[2]  = mk(71,  1, 0, 0, 315, 235,   4, 217, 0, 0, 0, 0);
        tbl[3]  = mk(1,   1, 0, 0, 315, 235,   3, 217, 0, 0, 0, 0);
        tbl[4]  = mk(8,   1, 0, 0, 315, 235,   3, 217, 0, 0, 0, 0);
        tbl[5]  = mk(10,  1, 1, 0, 315, 235,   3, 217, 0, 0, 0, 0);
        tbl[6]  = mk(142, 0, 1, 0, 315, 235, 429, 217, 0, 0, 0, 0);
        tbl[7]  = mk(1,   0, 1, 0, 315, 235, 431, 217, 0, 0, 0, 0);
        tbl[8]  = mk(5,   0, 1, 0, 315, 235, 431, 217, 0, 0, 0, 0);
        tbl[9]  = mk(1,   0, 0, 1, 315, 235, 431, 217, 0, 0, 1, 0);
        tbl[10] = mk(1,   0, 0, 0, 317, 233, 431, 217, 0, 0, 1, 0);
        tbl[11] = mk(1,   0, 0, 0, 319, 231, 431, 217, 0, 0, 1, 0);
        tbl[12] = mk(1,   0, 0, 0, 321, 229, 431, 215, 0, 0, 1, 0);

        for (int v = 0; v < 13; v++) begin
            do_ticks(tbl[v].n, tbl[v].up, tbl[v].dn, tbl[v].srv);
            chk_all($sformatf("vec%0d", v), tbl[v].bx, tbl[v].by, tbl[v].lp, tbl[v].rp,
                    tbl[v].sl, tbl[v].sr, tbl[v].st, tbl[v].pt);
        end

        // Run A: left paddle moved to 271 so the returning ball is hit at the face.
        reset_with_tick();
        chk_all("reset_mid_play", 315, 235, 217, 217, 0, 0, 0, 0);
        do_ticks(18, 0, 1, 0);
        chk("a_paddle_271", 16'(left_paddle), 271);
        @(negedge clk);
        btn_up = 1'b1; serve = 1'b1;
        repeat (4) @(negedge clk);
        chk("a_no_tick_paddle", 16'(left_paddle), 271);
        chk("a_no_tick_state", 16'(state), 0);
        btn_up = 1'b0; serve = 1'b0;
        do_ticks(1, 0, 0, 0);
        chk("a_serve_not_latched", 16'(state), 0);
        do_ticks(1, 0, 0, 1);
        do_ticks(442, 0, 0, 0);
        chk("a_pre_hit_x", 16'(ball_x), 22);
        chk("a_pre_hit_y", 16'(ball_y), 283);
        chk("a_pre_hit_state", 16'(state), 1);
        do_ticks(1, 0, 0, 0);
        chk("a_hit_x", 16'(ball_x), 20);
        chk("a_hit_y", 16'(ball_y), 281);
        do_ticks(1, 0, 0, 0);
        chk("a_after_hit_x", 16'(ball_x), 22);
        chk("a_after_hit_y", 16'(ball_y), 279);
        reset_with_tick();
        chk_all("reset_after_a", 315, 235, 217, 217, 0, 0, 0, 0);

        // Run B: paddle left at 217 never overlaps, so the player keeps missing.
        do_ticks(1, 0, 0, 1);
        do_ticks(442, 0, 0, 0);
        chk("b_pre_face_x", 16'(ball_x), 22);
        do_ticks(1, 0, 0, 0);
        chk("b_miss_x", 16'(ball_x), 20);
        do_ticks(8, 0, 0, 0);
        chk("b_edge_x", 16'(ball_x), 4);
        chk("b_edge_state", 16'(state), 1);
        chk("b_edge_score", 16'(score_right), 0);
        do_ticks(1, 0, 0, 0);
        chk("b_score", 16'(score_right), 1);
        chk("b_point_pulse", 16'(point), 1);
        chk("b_state_point", 16'(state), 2);
        chk("b_frozen_x", 16'(ball_x), 4);
        chk("b_frozen_y", 16'(ball_y), 263);
        @(negedge clk);
        chk("b_point_drop", 16'(point), 0);
        do_ticks(59, 0, 0, 0);
        chk("b_pause59_state", 16'(state), 2);
        chk("b_pause59_x", 16'(ball_x), 4);
        chk("b_pause59_y", 16'(ball_y), 263);
        chk("b_pause59_point", 16'(point), 0);
        do_ticks(1, 0, 0, 0);
        chk("b_pause60_state", 16'(state), 0);
        chk("b_pause60_x", 16'(ball_x), 315);
        chk("b_pause60_y", 16'(ball_y), 235);
        chk("b_pause60_score", 16'(score_right), 1);
        do_ticks(3, 0, 0, 0);
        chk("b_serve_idle", 16'(state), 0);

        for (int p = 2; p <= 7; p++) begin
            do_ticks(1, 0, 0, 1);
            do_ticks(156, 0, 0, 0);
            chk($sformatf("p%0d_edge_x", p), 16'(ball_x), 3);
            chk($sformatf("p%0d_edge_state", p), 16'(state), 1);
            do_ticks(1, 0, 0, 0);
            chk($sformatf("p%0d_score", p), 16'(score_right), p);
            chk($sformatf("p%0d_point", p), 16'(point), 1);
            chk($sformatf("p%0d_state", p), 16'(state), (p == 7) ? 3 : 2);
            chk($sformatf("p%0d_y", p), 16'(ball_y), 387);
            if (p < 7) begin
                do_ticks(60, 0, 0, 0);
                chk($sformatf("p%0d_back_to_serve", p), 16'(state), 0);
            end
        end

        do_ticks(5, 1, 0, 0);
        chk("go_state", 16'(state), 3);
        chk("go_score", 16'(score_right), 7);
        chk("go_paddle_frozen", 16'(left_paddle), 217);
        chk("go_ball_x", 16'(ball_x), 3);
        chk("go_ball_y", 16'(ball_y), 387);
        chk("go_point", 16'(point), 0);
        do_ticks(1, 0, 0, 1);
        chk_all("go_restart", 315, 235, 217, 217, 0, 0, 0, 0);

        // Reset lands on the very tick that would have scored.
        do_ticks(1, 0, 0, 1);
        do_ticks(156, 0, 0, 0);
        chk("rc_edge_x", 16'(ball_x), 3);
        chk("rc_edge_state", 16'(state), 1);
        reset_with_tick();
        chk_all("rc_reset", 315, 235, 217, 217, 0, 0, 0, 0);
        @(negedge clk);
        chk("rc_point_quiet", 16'(point), 0);
        chk("rc_score_quiet", 16'(score_right), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
